systolic_input_skewer: RTL
==========================

SYSTOLIC_INPUT_SKEWER -- requirements
Module: systolic_input_skewer

Interface
REQ-001 SHALL have parameter ROWS, default 8: number of PE rows fed, each lane with its own delay; ROWS >= 2.
REQ-002 SHALL have parameter DATA_IN_BW, default 8: signed activation width per lane, equal to the PE DIN width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers an activation vector.
REQ-006 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-007 SHALL have port in_data  input  ROWS*DATA_IN_BW  activation vector; lane r occupies bits [r*DATA_IN_BW +: DATA_IN_BW].
REQ-008 SHALL have port in_last  input  1  marks the final vector of a tile; qualified by in_valid.
REQ-009 SHALL have port skew_out  output  ROWS*DATA_IN_BW  skewed activations, lane r drives DIN of PE row r.
REQ-010 SHALL have port skew_valid  output  ROWS  per-lane valid of skew_out.
REQ-011 SHALL have port busy  output  1  high while state is STREAM or DRAIN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the last tile element leaves lane ROWS-1.

Function
REQ-013 SHALL accept a vector on any cycle where in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready = 1 in IDLE and STREAM, 0 in DRAIN, and 0 while rst is high.
REQ-015 SHALL present lane r of a vector accepted in cycle t on skew_out lane r in cycle t+1+r, with skew_valid[r] = 1 in that cycle.
REQ-016 SHALL, on a STREAM cycle with no acceptance, insert a bubble: an entry with value 0 and valid 0 that follows the same per-lane delays.
REQ-017 SHALL drive skew_out lane r to 0 whenever skew_valid[r] = 0, so idle PE rows add 0 to the partial sum.
REQ-018 SHALL pass lane data bit-exact with no width change or saturation (e.g. -128 and 127 unchanged at DATA_IN_BW=8).
REQ-019 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-020 SHALL transition IDLE->STREAM on acceptance with in_last=0, IDLE->DRAIN on acceptance with in_last=1, and stay in IDLE otherwise.
REQ-021 SHALL transition STREAM->DRAIN on acceptance with in_last=1, and stay in STREAM otherwise, including during bubbles.
REQ-022 SHALL, when the last vector is accepted in cycle t, remain in DRAIN for cycles t+1..t+ROWS-1, counted by a $clog2(ROWS)-bit counter that is cleared on DRAIN entry.
REQ-023 SHALL return to IDLE in cycle t+ROWS and assert done in that cycle only, coincident with skew_valid[ROWS-1] for the last vector.
REQ-024 SHALL keep in_ready high in the done cycle, so a new tile may be accepted at t+ROWS with no lane overlap.
REQ-025 SHALL ignore in_valid and in_last during DRAIN; upstream holds its vector and data.
REQ-026 SHALL ignore in_last when in_valid = 0.

Reset
REQ-027 SHALL, in any cycle with rst high, set next state IDLE, the drain counter to 0, all delay-stage data and valid bits to 0, skew_out to 0, skew_valid to 0, done to 0 and busy to 0.
REQ-028 SHALL, on reset asserted mid-STREAM or mid-DRAIN, discard all in-flight entries with no done pulse, and reach IDLE with in_ready = 1 in the first cycle after rst deasserts.

Verification (ROWS=4, DATA_IN_BW=8)
REQ-029 SHALL cover single vector: lanes 3..0 = {4,3,2,1} with in_last accepted at c0 -> lane0=1 @c1, lane1=2 @c2, lane2=3 @c3, lane3=4 @c4; done @c4; in_ready=0 @c1-c3.
REQ-030 SHALL cover back-to-back tile: vectors A,B,C at c0-c2, last on C -> each lane valid 3 consecutive cycles starting c1+r; done @c6.
REQ-031 SHALL cover bubble: vectors at c0 and c2, in_valid=0 @c1 -> every lane shows valid,0,valid with value 0 in the gap cycle.
REQ-032 SHALL cover signed extremes: lane values -128 and 127 -> emerged values are exactly 0x80 and 0x7F.
REQ-033 SHALL cover reset mid-DRAIN: rst high at c2 of the REQ-029 scenario -> skew_valid=0 and skew_out=0 from c3; no done; in_ready=1 after rst low.
REQ-034 SHALL cover held request: in_valid held high with vector D from c1 of the REQ-029 scenario -> D not accepted before c4; accepted @c4; lane0=D0 @c5.

Source files
------------

// File: rtl/systolic_input_skewer.sv
// Skews an activation vector across ROWS lanes so lane r reaches PE row r
// r cycles after lane 0, tracking tile boundaries with an IDLE/STREAM/DRAIN FSM.
module systolic_input_skewer #(
  parameter int ROWS       = 8,
  parameter int DATA_IN_BW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_IN_BW-1:0]   in_data,
  input  logic                         in_last,
  output logic [ROWS*DATA_IN_BW-1:0]   skew_out,
  output logic [ROWS-1:0]              skew_valid,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  localparam int CNT_W = $clog2(ROWS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_accept;

  // Handshake: a vector transfers on any cycle where in_valid && in_ready;
  // in_ready never depends on in_valid, and upstream holds data while stalled.
  assign in_ready  = !rst && (r_state != S_DRAIN);
  assign busy      = !rst && (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign done      = r_done;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_accept) begin
            r_state <= in_last ? S_DRAIN : S_STREAM;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          // Leave after ROWS-1 drain cycles so done lines up with lane ROWS-1.
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_IN_BW-1:0] r_d [0:r];
    logic                  r_v [0:r];

    // Non-accept cycles load a zero bubble, so invalid slots always carry 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          r_d[k] <= '0;
          r_v[k] <= 1'b0;
        end
      end else begin
        r_d[0] <= w_accept ? in_data[r*DATA_IN_BW +: DATA_IN_BW] : '0;
        r_v[0] <= w_accept;
        for (int k = 1; k <= r; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign skew_out[r*DATA_IN_BW +: DATA_IN_BW] = r_d[r];
    assign skew_valid[r]                        = r_v[r];
  end

endmodule
